// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU constants used by the register-file writeback path.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // x0 is hardwired to zero: writes to it are consumed but never committed.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  int   idx;
  logic found;

  // Walk the requesters in priority order starting at ptr, wrapping at N.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback sequencer for the single register-file write port: round-robin
// arbitration over producers, a registered write stage, and a pending-write
// scoreboard that decode uses to detect RAW hazards on multi-cycle results.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]         w_address,
  output logic [DATA_W-1:0]             w_data,
  output logic                          w_enable,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_addr,
  output logic                          issue_ready,
  input  logic [REG_ADDR_W-1:0]         rs1_addr,
  input  logic [REG_ADDR_W-1:0]         rs2_addr,
  output logic                          hazard
);

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      nxt_ptr;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr_p0;
  logic [DATA_W-1:0]     sel_data_p0;

  logic [REG_ADDR_W-1:0] wb_addr_p1;
  logic [DATA_W-1:0]     wb_data_p1;
  logic                  vld_p1;

  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic                  issue_fire;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grant only while running and out of reset; a grant is a transfer.
  always_comb begin
    req_ready = (clk_enable && rst_n) ? grant : '0;
    xfer      = |req_ready;
  end

  // Mux the granted requester's address/data and index out of the packed buses.
  always_comb begin
    gnt_idx     = '0;
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx     = IDX_W'(i);
        sel_addr_p0 = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data_p0 = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping at NUM_REQ.
  always_comb begin
    if (gnt_idx == IDX_W'(NUM_REQ - 1)) nxt_ptr = '0;
    else                                nxt_ptr = gnt_idx + IDX_W'(1);
  end

  // ---- stage p0 -> p1: capture the winning result into the write stage ----
  // Output stage register; x0 writes are consumed without raising w_enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (clk_enable) begin
      if (xfer) begin
        wb_addr_p1 <= sel_addr_p0;
        wb_data_p1 <= sel_data_p0;
        vld_p1     <= !is_zero_reg(sel_addr_p0);
      end else begin
        vld_p1     <= 1'b0;
      end
    end
  end

  // Round-robin pointer advances only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rr_ptr <= '0;
    else if (clk_enable && xfer) rr_ptr <= nxt_ptr;
  end

  assign w_address = wb_addr_p1;
  assign w_data    = wb_data_p1;
  assign w_enable  = vld_p1;

  // One outstanding write per register; x0 never blocks issue.
  always_comb begin
    issue_ready = !pending[issue_addr] || is_zero_reg(issue_addr);
    issue_fire  = issue_valid && issue_ready && clk_enable && !is_zero_reg(issue_addr);
    hazard      = pending[rs1_addr] || pending[rs2_addr];
  end

  // Scoreboard update: clear the committing register, then set the issued
  // one so a same-cycle set and clear on one register leaves it pending.
  always_comb begin
    pending_nxt = pending;
    if (vld_p1)     pending_nxt[wb_addr_p1] = 1'b0;
    if (issue_fire) pending_nxt[issue_addr] = 1'b1;
    pending_nxt[ZERO_REG] = 1'b0;
  end

  // Scoreboard register, frozen while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pending <= '0;
    else if (clk_enable) pending <= pending_nxt;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter with a queue scoreboard.
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clk_enable = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [5*N-1:0]  req_addr = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [4:0]      w_address;
  logic [31:0]     w_data;
  logic            w_enable;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_addr = '0;
  logic            issue_ready;
  logic [4:0]      rs1_addr = '0;
  logic [4:0]      rs2_addr = '0;
  logic            hazard;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_enable  (clk_enable),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .w_address   (w_address),
    .w_data      (w_data),
    .w_enable    (w_enable),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .hazard      (hazard)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  int         n_checks = 0;
  int         n_pass = 0;
  wr_t        sb_q[$];
  logic [4:0] inflight[$];
  bit         pend_m[32];
  int         rr_m = 0;
  wr_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each enabled w_enable cycle is one register-file commit.
  always @(negedge clk) begin
    if (rst_n && w_enable && clk_enable) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_addr", 32'(w_address), 32'(mon_e.a));
        check("wb_data", w_data, mon_e.d);
      end
    end
  end

  // One clock of stimulus, checking combinational outputs against the model.
  task automatic step(input logic [N-1:0] v, input logic [5*N-1:0] a,
                      input logic [32*N-1:0] d, input logic iv, input logic [4:0] ia,
                      input logic [4:0] r1, input logic [4:0] r2, input logic ce);
    logic [N-1:0] g;
    int           gi;
    int           idx;
    bit           ir;
    wr_t          w;
    req_valid   = v;
    req_addr    = a;
    req_data    = d;
    issue_valid = iv;
    issue_addr  = ia;
    rs1_addr    = r1;
    rs2_addr    = r2;
    clk_enable  = ce;
    @(negedge clk);
    g  = '0;
    gi = -1;
    if (ce) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr_m + k) % N;
        if (gi < 0 && v[idx]) gi = idx;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    ir = (ia == 5'd0) || !pend_m[ia];
    check("req_ready", 32'(req_ready), 32'(g));
    check("issue_ready", 32'(issue_ready), 32'(ir));
    check("hazard", 32'(hazard), 32'(pend_m[r1] || pend_m[r2]));
    check("w_enable", 32'(w_enable), 32'(inflight.size() != 0));
    @(posedge clk);
    if (ce) begin
      if (inflight.size() != 0) pend_m[inflight.pop_front()] = 1'b0;
      if (iv && ir && ia != 5'd0) pend_m[ia] = 1'b1;
      if (gi >= 0) begin
        rr_m = (gi + 1) % N;
        if (a[5*gi +: 5] != 5'd0) begin
          inflight.push_back(a[5*gi +: 5]);
          w.a = a[5*gi +: 5];
          w.d = d[32*gi +: 32];
          sb_q.push_back(w);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r1);
    step('0, '0, '0, 1'b0, r1, r1, 5'd0, 1'b1);
  endtask

  logic [N-1:0]    rv;
  logic [5*N-1:0]  ra;
  logic [32*N-1:0] rd;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset holds outputs low even with requests pending.
    req_valid  = 3'b111;
    clk_enable = 1'b1;
    #2;
    check("rst_w_enable", 32'(w_enable), 32'd0);
    check("rst_w_address", 32'(w_address), 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request to x5.
    step(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(5'd0);
    idle(5'd0);

    // All requesters valid for six cycles.
    for (int i = 0; i < 6; i++)
      step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hC0 + 32'(i), 32'hB0 + 32'(i), 32'hA0 + 32'(i)},
           1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(5'd0);

    // Issue x7, re-issue blocked, requester 1 writes x7 and the hazard drops.
    step('0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1);
    step('0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1);
    step(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h7777_0007, 32'd0}, 1'b0, 5'd7, 5'd7, 5'd0, 1'b1);
    idle(5'd7);
    idle(5'd7);

    // Write to x9 committing in the same cycle as an issue to x9: stays pending.
    step(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'h9999}, 1'b0, 5'd0, 5'd9, 5'd0, 1'b1);
    step('0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1);
    idle(5'd9);
    idle(5'd9);
    step(3'b100, {5'd9, 5'd0, 5'd0}, {32'h9A9A, 32'd0, 32'd0}, 1'b0, 5'd9, 5'd9, 5'd9, 1'b1);
    idle(5'd9);
    idle(5'd9);

    // Address-0 request is granted but never written.
    step('0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1);
    step(3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h1234}, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1);
    idle(5'd3);

    // Stall with requests valid and a write in the output stage.
    step(3'b111, {5'd6, 5'd4, 5'd3}, {32'h66, 32'h44, 32'h33}, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(3'b111, {5'd6, 5'd4, 5'd3}, {32'h66, 32'h44, 32'h33}, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0);
    step(3'b111, {5'd6, 5'd4, 5'd3}, {32'h66, 32'h44, 32'h33}, 1'b0, 5'd0, 5'd3, 5'd8, 1'b1);
    idle(5'd3);
    idle(5'd3);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      rv = N'($urandom);
      ra = {5'($urandom), 5'($urandom), 5'($urandom)};
      rd = {$urandom, $urandom, $urandom};
      step(rv, ra, rd, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), ($urandom % 5) != 0);
    end
    idle(5'd0);
    idle(5'd0);

    // Asynchronous reset in the middle of a write with x13 pending.
    step('0, '0, '0, 1'b1, 5'd13, 5'd13, 5'd0, 1'b1);
    step(3'b001, {5'd0, 5'd0, 5'd20}, {32'd0, 32'd0, 32'h2020}, 1'b0, 5'd13, 5'd13, 5'd0, 1'b1);
    check("pre_rst_w_enable", 32'(w_enable), 32'd1);
    req_valid = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_w_enable", 32'(w_enable), 32'd0);
    check("async_rst_w_address", 32'(w_address), 32'd0);
    check("async_rst_hazard", 32'(hazard), 32'd0);
    check("async_rst_issue_ready", 32'(issue_ready), 32'd1);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    rr_m = 0;
    inflight.delete();
    sb_q.delete();
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(3'b111, {5'd23, 5'd22, 5'd21}, {32'h23, 32'h22, 32'h21}, 1'b0, 5'd13, 5'd13, 5'd0, 1'b1);
    idle(5'd13);
    idle(5'd0);
    idle(5'd0);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
